// File: rtl/ahb_arbiter_slave_if.sv
// Bus bundle between the masters' address decoders and one slave-side arbiter.
// htrans per master uses AHB encoding: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
interface ahb_arbiter_slave_if #(
  parameter int SLAVE_X_MASTER_NUM = 3,
  parameter int MASTER_ID_WIDTH    = 2
);
  logic [SLAVE_X_MASTER_NUM-1:0]       hreq;
  logic [SLAVE_X_MASTER_NUM-1:0][1:0]  htrans;
  logic                                hready;
  logic [SLAVE_X_MASTER_NUM-1:0]       hgrant;
  logic                                hsel;
  logic [MASTER_ID_WIDTH-1:0]          hmaster_addr;
  logic [MASTER_ID_WIDTH-1:0]          hmaster_data;
  logic                                hmaster_data_valid;

  modport master (
    output hreq, htrans, hready,
    input  hgrant, hsel, hmaster_addr, hmaster_data, hmaster_data_valid
  );

  modport slave (
    input  hreq, htrans, hready,
    output hgrant, hsel, hmaster_addr, hmaster_data, hmaster_data_valid
  );
endinterface

// File: rtl/ahb_arbiter_slave.sv
// Per-slave round-robin arbiter: one owner at a time, bounded hold time that
// never splits a burst, and address/data-phase owner tracking.
module ahb_arbiter_slave #(
  parameter int SLAVE_X_MASTER_NUM = 3,
  parameter int MASTER_ID_WIDTH    = 2,
  parameter int MAX_HOLD           = 16
) (
  input  logic               hclk,
  input  logic               hreset_n,
  ahb_arbiter_slave_if.slave bus
);
  localparam int N  = SLAVE_X_MASTER_NUM;
  localparam int W  = MASTER_ID_WIDTH;
  localparam int HW = $clog2(MAX_HOLD + 1);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_t;

  arb_state_t      r_state, w_state_nxt;
  logic [N-1:0]    r_hgrant, w_hgrant_nxt;
  logic [W-1:0]    r_rr_ptr, w_rr_ptr_nxt;
  logic [HW-1:0]   r_hold_cnt, w_hold_cnt_nxt;
  logic [W-1:0]    r_hmaster_data;
  logic            r_hmaster_data_valid;

  logic [W-1:0]    w_owner;
  logic [1:0]      w_owner_trans;
  logic            w_owner_xfer;
  logic            w_hsel;
  logic            w_others_req;
  logic            w_hold_expired;
  logic            w_release;
  logic [N-1:0]    w_winner;
  logic [W-1:0]    w_winner_idx;

  // First requester strictly after ptr, ascending with wrap; ptr itself is checked last.
  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] req, input logic [W-1:0] ptr);
    logic [N-1:0] pick;
    logic         found;
    int           idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      for (int j = 0; j < N; j++) begin
        if (!found && (j == idx) && req[j]) begin
          pick[j] = 1'b1;
          found   = 1'b1;
        end
      end
    end
    return pick;
  endfunction

  function automatic logic [W-1:0] onehot_to_idx(input logic [N-1:0] oh);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) idx = idx | W'(i);
    end
    return idx;
  endfunction

  assign w_owner        = onehot_to_idx(r_hgrant);
  assign w_owner_trans  = bus.htrans[w_owner];
  assign w_owner_xfer   = (w_owner_trans == HTRANS_NONSEQ) || (w_owner_trans == HTRANS_SEQ);
  assign w_hsel         = (|(r_hgrant & bus.hreq)) && w_owner_xfer;
  assign w_others_req   = |(bus.hreq & ~r_hgrant);
  assign w_hold_expired = (r_hold_cnt >= HW'(MAX_HOLD));
  // Hold-time preemption only between transfers: SEQ/BUSY mean a burst is still open.
  assign w_release      = !bus.hreq[w_owner] || (w_owner_trans == HTRANS_IDLE) ||
                          (w_hold_expired && w_others_req &&
                           (w_owner_trans != HTRANS_SEQ) && (w_owner_trans != HTRANS_BUSY));
  assign w_winner       = rr_pick(bus.hreq, r_rr_ptr);
  assign w_winner_idx   = onehot_to_idx(w_winner);

  // Next-state, grant, pointer and hold-counter logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_hgrant_nxt   = r_hgrant;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_hold_cnt_nxt = r_hold_cnt;
    if (bus.hready) begin
      case (r_state)
        ARB_IDLE: begin
          if (|bus.hreq) begin
            w_state_nxt    = ARB_OWNED;
            w_hgrant_nxt   = w_winner;
            w_rr_ptr_nxt   = w_winner_idx;
            w_hold_cnt_nxt = {HW{1'b0}};
          end else begin
            w_hgrant_nxt   = {N{1'b0}};
          end
        end
        ARB_OWNED: begin
          if (w_release) begin
            w_hold_cnt_nxt = {HW{1'b0}};
            // rr_ptr sits on the owner, so it is only re-picked when alone.
            if (|bus.hreq) begin
              w_hgrant_nxt = w_winner;
              w_rr_ptr_nxt = w_winner_idx;
            end else begin
              w_state_nxt  = ARB_IDLE;
              w_hgrant_nxt = {N{1'b0}};
            end
          end else if (w_owner_xfer && !w_hold_expired) begin
            w_hold_cnt_nxt = r_hold_cnt + HW'(1);
          end else begin
            w_hold_cnt_nxt = r_hold_cnt;
          end
        end
        default: begin
          w_state_nxt  = ARB_IDLE;
          w_hgrant_nxt = {N{1'b0}};
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Arbitration state register; the comb logic already holds values while hready=0.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_state    <= ARB_IDLE;
      r_hgrant   <= {N{1'b0}};
      r_rr_ptr   <= W'(N - 1);
      r_hold_cnt <= {HW{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_hgrant   <= w_hgrant_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  // Data-phase owner pipeline stage.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_hmaster_data       <= {W{1'b0}};
      r_hmaster_data_valid <= 1'b0;
    end else if (bus.hready) begin
      r_hmaster_data       <= w_owner;
      r_hmaster_data_valid <= w_hsel;
    end else begin
      r_hmaster_data       <= r_hmaster_data;
      r_hmaster_data_valid <= r_hmaster_data_valid;
    end
  end

  assign bus.hgrant             = r_hgrant;
  assign bus.hsel               = w_hsel;
  assign bus.hmaster_addr       = w_owner;
  assign bus.hmaster_data       = r_hmaster_data;
  assign bus.hmaster_data_valid = r_hmaster_data_valid;
endmodule

// File: tb/tb_ahb_arbiter_slave.sv
// Directed bench for ahb_arbiter_slave: per-cycle expectations go through a
// scoreboard queue and are compared after the clock edge.
module tb_ahb_arbiter_slave;
  localparam int N    = 3;
  localparam int W    = 2;
  localparam int MAXH = 4;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NS   = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  typedef struct {
    logic [N-1:0] grant;
    logic [W-1:0] data;
    logic         valid;
    int           hold;
  } exp_t;

  logic hclk     = 1'b0;
  logic hreset_n = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;
  int step_no  = 0;

  exp_t sb_q[$];

  logic [N-1:0] m_grant;
  logic [W-1:0] m_data;
  logic         m_valid;

  ahb_arbiter_slave_if #(.SLAVE_X_MASTER_NUM(N), .MASTER_ID_WIDTH(W)) bus();

  ahb_arbiter_slave #(
    .SLAVE_X_MASTER_NUM(N),
    .MASTER_ID_WIDTH(W),
    .MAX_HOLD(MAXH)
  ) dut (
    .hclk(hclk),
    .hreset_n(hreset_n),
    .bus(bus)
  );

  always #5 hclk = ~hclk;

  always @(negedge hclk) begin
    n_assert++;
    assert ($onehot0(bus.hgrant)) else begin
      n_fail++;
      $error("FAIL onehot0_hgrant observed=%b expected=at-most-one-bit", bus.hgrant);
    end
  end

  function automatic logic [W-1:0] oh_idx(input logic [N-1:0] oh);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (oh[i]) r = W'(i);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL step %0d %s observed=%0h expected=%0h", step_no, tag, obs, exp);
    end
  endtask

  // One bus cycle: drive inputs, check hsel, queue expected post-edge state, compare after edge.
  task automatic cyc(input logic [N-1:0] req, input logic [1:0] t2, input logic [1:0] t1,
                     input logic [1:0] t0, input logic rdy, input logic [N-1:0] exp_grant,
                     input int exp_hold);
    logic [N-1:0][1:0] tr;
    logic [W-1:0]      a;
    logic              sel;
    exp_t              e;
    step_no++;
    tr         = {t2, t1, t0};
    bus.hreq   = req;
    bus.htrans = tr;
    bus.hready = rdy;
    a   = oh_idx(m_grant);
    sel = (|(m_grant & req)) && ((tr[a] == T_NS) || (tr[a] == T_SEQ));
    #1;
    check("hsel", 32'(bus.hsel), 32'(sel));
    if (rdy) begin
      m_data  = a;
      m_valid = sel;
    end
    e.grant = exp_grant;
    e.data  = m_data;
    e.valid = m_valid;
    e.hold  = exp_hold;
    sb_q.push_back(e);
    @(posedge hclk);
    #1;
    e = sb_q.pop_front();
    check("hgrant", 32'(bus.hgrant), 32'(e.grant));
    check("hmaster_addr", 32'(bus.hmaster_addr), 32'(oh_idx(e.grant)));
    check("hmaster_data", 32'(bus.hmaster_data), 32'(e.data));
    check("hmaster_data_valid", 32'(bus.hmaster_data_valid), 32'(e.valid));
    if (e.hold >= 0) check("hold_cnt", 32'(dut.r_hold_cnt), e.hold);
    m_grant = e.grant;
  endtask

  initial begin
    bus.hreq   = '0;
    bus.htrans = '0;
    bus.hready = 1'b1;
    m_grant = '0;
    m_data  = '0;
    m_valid = 1'b0;

    // Reset values
    repeat (2) @(posedge hclk);
    #1;
    check("rst_hgrant", 32'(bus.hgrant), 32'd0);
    check("rst_hsel", 32'(bus.hsel), 32'd0);
    check("rst_hmaster_data", 32'(bus.hmaster_data), 32'd0);
    check("rst_hmaster_data_valid", 32'(bus.hmaster_data_valid), 32'd0);
    check("rst_rr_ptr", 32'(dut.r_rr_ptr), 32'd2);
    check("rst_hold_cnt", 32'(dut.r_hold_cnt), 32'd0);
    hreset_n = 1'b1;

    // Round robin 0,1,2,0 with no idle cycle between owners
    cyc(3'b111, T_IDLE, T_IDLE, T_IDLE, 1'b1, 3'b001, 0);
    cyc(3'b111, T_IDLE, T_IDLE, T_NS,   1'b1, 3'b001, 1);
    cyc(3'b111, T_IDLE, T_IDLE, T_IDLE, 1'b1, 3'b010, 0);
    cyc(3'b111, T_IDLE, T_NS,   T_IDLE, 1'b1, 3'b010, 1);
    cyc(3'b111, T_IDLE, T_IDLE, T_IDLE, 1'b1, 3'b100, 0);
    cyc(3'b111, T_NS,   T_IDLE, T_IDLE, 1'b1, 3'b100, 1);
    cyc(3'b111, T_IDLE, T_IDLE, T_IDLE, 1'b1, 3'b001, 0);
    cyc(3'b111, T_IDLE, T_IDLE, T_NS,   1'b1, 3'b001, 1);
    cyc(3'b000, T_IDLE, T_IDLE, T_IDLE, 1'b1, 3'b000, 0);

    // Single request from master 1
    cyc(3'b010, T_IDLE, T_NS,   T_IDLE, 1'b1, 3'b010, 0);
    cyc(3'b010, T_IDLE, T_NS,   T_IDLE, 1'b1, 3'b010, 1);
    cyc(3'b000, T_IDLE, T_IDLE, T_IDLE, 1'b1, 3'b000, 0);

    // Burst protection: NONSEQ + 7 SEQ from master 0 while master 2 waits
    cyc(3'b001, T_IDLE, T_IDLE, T_IDLE, 1'b1, 3'b001, 0);
    cyc(3'b101, T_IDLE, T_IDLE, T_NS,   1'b1, 3'b001, 1);
    for (int b = 0; b < 7; b++) begin
      cyc(3'b101, T_IDLE, T_IDLE, T_SEQ, 1'b1, 3'b001, (b + 2 > MAXH) ? MAXH : b + 2);
    end
    cyc(3'b101, T_IDLE, T_IDLE, T_IDLE, 1'b1, 3'b100, 0);

    // Wait states: master 1 owns, master 0 requests, hready low for 3 cycles
    cyc(3'b010, T_IDLE, T_IDLE, T_IDLE, 1'b1, 3'b010, 0);
    cyc(3'b011, T_IDLE, T_IDLE, T_IDLE, 1'b0, 3'b010, 0);
    cyc(3'b011, T_IDLE, T_NS,   T_IDLE, 1'b0, 3'b010, 0);
    cyc(3'b011, T_IDLE, T_NS,   T_IDLE, 1'b0, 3'b010, 0);
    cyc(3'b011, T_IDLE, T_NS,   T_IDLE, 1'b1, 3'b010, 1);
    cyc(3'b011, T_IDLE, T_IDLE, T_IDLE, 1'b1, 3'b001, 0);

    // Sole requester keeps the bus with hold_cnt saturated
    cyc(3'b010, T_IDLE, T_IDLE, T_IDLE, 1'b1, 3'b010, 0);
    for (int k = 1; k <= 6; k++) begin
      cyc(3'b010, T_IDLE, T_NS, T_IDLE, 1'b1, 3'b010, (k > MAXH) ? MAXH : k);
    end
    cyc(3'b000, T_IDLE, T_IDLE, T_IDLE, 1'b1, 3'b000, 0);

    // Reset during a SEQ beat of master 2
    cyc(3'b100, T_IDLE, T_IDLE, T_IDLE, 1'b1, 3'b100, 0);
    cyc(3'b100, T_NS,   T_IDLE, T_IDLE, 1'b1, 3'b100, 1);
    bus.hreq   = 3'b100;
    bus.htrans = {T_SEQ, T_IDLE, T_IDLE};
    #2;
    check("pre_rst_hsel", 32'(bus.hsel), 32'd1);
    check("pre_rst_data_valid", 32'(bus.hmaster_data_valid), 32'd1);
    check("pre_rst_data", 32'(bus.hmaster_data), 32'd2);
    hreset_n = 1'b0;
    #1;
    check("async_rst_hgrant", 32'(bus.hgrant), 32'd0);
    check("async_rst_hsel", 32'(bus.hsel), 32'd0);
    check("async_rst_data_valid", 32'(bus.hmaster_data_valid), 32'd0);
    check("async_rst_data", 32'(bus.hmaster_data), 32'd0);
    @(posedge hclk);
    #1;
    hreset_n = 1'b1;
    m_grant = '0;
    m_data  = '0;
    m_valid = 1'b0;
    cyc(3'b101, T_IDLE, T_IDLE, T_IDLE, 1'b1, 3'b001, 0);
    cyc(3'b101, T_IDLE, T_IDLE, T_IDLE, 1'b1, 3'b100, 0);
    cyc(3'b000, T_IDLE, T_IDLE, T_IDLE, 1'b1, 3'b000, 0);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
